// File: rtl/img_loader.sv
// img_loader: packs an R,G,B byte stream into 24-bit pixels and writes them
// linearly into the image BRAM that the 720p painter reads. One frame is
// loaded per start pulse; busy/done report progress to the top level.
//
// Optional build macro IMG_LOADER_CKSUM_EN adds an 8-bit cksum output. It
// holds the running modulo-256 sum of every byte accepted since the last
// start.
module img_loader #(
  parameter int IMG_WIDTH  = 200,
  parameter int IMG_HEIGHT = 112,
  parameter int ADDR_W     = 15
) (
  input  logic              clk_pix,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [23:0]       wdata,
  output logic              busy,
`ifdef IMG_LOADER_CKSUM_EN
  output logic              done,
  output logic [7:0]        cksum
`else
  output logic              done
`endif
);

  localparam int              NUM_PIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIX - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [1:0]        byte_idx_r;
  logic [ADDR_W-1:0] pix_cnt_r;
  logic [7:0]        red_r;
  logic [7:0]        green_r;
  logic              we_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [23:0]       wdata_r;
  logic              accept_s;
  logic              last_s;
  logic              restart_s;
`ifdef IMG_LOADER_CKSUM_EN
  logic [7:0]        cksum_r;
`endif

  // A start pulse only matters outside LOAD; inside LOAD it is ignored.
  assign restart_s = start && (state_r != ST_LOAD);
  // Byte handshake; s_ready is a pure decode of the state register.
  assign accept_s  = s_valid && (state_r == ST_LOAD);
  // Blue byte of the final pixel ends the frame.
  assign last_s    = accept_s && (byte_idx_r == 2'd2) && (pix_cnt_r == LAST_PIX);

  // State register.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    state_s = state_r;
    s_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Byte packing, pixel counter and the registered BRAM write port.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_r <= 2'd0;
      pix_cnt_r  <= '0;
      red_r      <= 8'd0;
      green_r    <= 8'd0;
      we_r       <= 1'b0;
      waddr_r    <= '0;
      wdata_r    <= 24'd0;
    end else begin
      we_r <= 1'b0;
      if (restart_s) begin
        // Fresh frame: no partial pixel may leak from a previous run.
        byte_idx_r <= 2'd0;
        pix_cnt_r  <= '0;
        red_r      <= 8'd0;
        green_r    <= 8'd0;
      end else if (accept_s) begin
        case (byte_idx_r)
          2'd0: begin
            red_r      <= s_data;
            byte_idx_r <= 2'd1;
          end
          2'd1: begin
            green_r    <= s_data;
            byte_idx_r <= 2'd2;
          end
          2'd2: begin
            we_r       <= 1'b1;
            waddr_r    <= pix_cnt_r;
            wdata_r    <= {red_r, green_r, s_data};
            pix_cnt_r  <= pix_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            byte_idx_r <= 2'd0;
          end
          default: begin
            byte_idx_r <= 2'd0;
          end
        endcase
      end
    end
  end

`ifdef IMG_LOADER_CKSUM_EN
  // Running modulo-256 byte sum, cleared whenever a new frame starts.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      cksum_r <= 8'd0;
    end else if (restart_s) begin
      cksum_r <= 8'd0;
    end else if (accept_s) begin
      cksum_r <= cksum_r + s_data;
    end
  end

  assign cksum = cksum_r;
`endif

  assign we    = we_r;
  assign waddr = waddr_r;
  assign wdata = wdata_r;

endmodule
